// File: rtl/alu_issue_queue_if.sv
// Command, ALU-drive and result bundle for alu_issue_queue.
// The res_zero signal exists only when ALU_ZERO_FLAG_EN is defined.
interface alu_issue_queue_if #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
);
   localparam int LVL_W = $clog2(DEPTH + 1);

   logic             cmd_valid;
   logic             cmd_ready;
   logic [3:0]       cmd_op;
   logic [WIDTH-1:0] cmd_a;
   logic [WIDTH-1:0] cmd_b;

   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [3:0]       alu_op;
   logic [WIDTH-1:0] alu_y;
   logic             alu_carry;

   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_y;
   logic             res_carry;
   logic [3:0]       res_op;
   logic             res_illegal;
   logic [LVL_W-1:0] level;
`ifdef ALU_ZERO_FLAG_EN
   logic             res_zero;
`endif

   modport slave (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_y, alu_carry, res_ready,
      output cmd_ready, alu_a, alu_b, alu_op,
      output res_valid, res_y, res_carry, res_op, res_illegal, level
`ifdef ALU_ZERO_FLAG_EN
      , output res_zero
`endif
   );

   modport master (
      output cmd_valid, cmd_op, cmd_a, cmd_b, alu_y, alu_carry, res_ready,
      input  cmd_ready, alu_a, alu_b, alu_op,
      input  res_valid, res_y, res_carry, res_op, res_illegal, level
`ifdef ALU_ZERO_FLAG_EN
      , input res_zero
`endif
   );
endinterface

// File: rtl/alu_issue_queue.sv
// Command FIFO feeding a combinational ALU, with a back-pressured result register.
// Optional zero flag on the result is enabled by defining ALU_ZERO_FLAG_EN.
module alu_issue_queue #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   alu_issue_queue_if.slave bus
);
   localparam int         PTR_W         = $clog2(DEPTH);
   localparam int         LVL_W         = $clog2(DEPTH + 1);
   localparam logic [3:0] LAST_LEGAL_OP = 4'd10;

   typedef struct packed {
      logic [3:0]       op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } cmd_t;

   cmd_t             mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;

   logic             res_valid_q, res_valid_d;
   logic [WIDTH-1:0] res_y_q, res_y_d;
   logic             res_carry_q, res_carry_d;
   logic [3:0]       res_op_q, res_op_d;
   logic             res_illegal_q, res_illegal_d;
`ifdef ALU_ZERO_FLAG_EN
   logic             res_zero_q, res_zero_d;
`endif

   cmd_t head;
   logic full, empty, push, issue, head_illegal;

   assign full         = (level_q == LVL_W'(DEPTH));
   assign empty        = (level_q == '0);
   assign push         = bus.cmd_valid & ~full;
   assign issue        = ~empty & (~res_valid_q | bus.res_ready);
   // Empty FIFO presents all-zero operands so the ALU never sees a stale entry.
   assign head         = empty ? '0 : mem_q[rd_ptr_q];
   assign head_illegal = (head.op > LAST_LEGAL_OP);

   assign bus.cmd_ready   = ~full;
   assign bus.level       = level_q;
   assign bus.alu_a       = head.a;
   assign bus.alu_b       = head.b;
   assign bus.alu_op      = head.op;
   assign bus.res_valid   = res_valid_q;
   assign bus.res_y       = res_y_q;
   assign bus.res_carry   = res_carry_q;
   assign bus.res_op      = res_op_q;
   assign bus.res_illegal = res_illegal_q;
`ifdef ALU_ZERO_FLAG_EN
   assign bus.res_zero    = res_zero_q;
`endif

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
      wr_ptr_d      = wr_ptr_q + PTR_W'(push);
      rd_ptr_d      = rd_ptr_q + PTR_W'(issue);
      level_d       = level_q + LVL_W'(push) - LVL_W'(issue);
      res_valid_d   = res_valid_q;
      res_y_d       = res_y_q;
      res_carry_d   = res_carry_q;
      res_op_d      = res_op_q;
      res_illegal_d = res_illegal_q;
`ifdef ALU_ZERO_FLAG_EN
      res_zero_d    = res_zero_q;
`endif
      if (issue) begin
         res_valid_d   = 1'b1;
         res_op_d      = head.op;
         res_illegal_d = head_illegal;
         res_y_d       = head_illegal ? '0 : bus.alu_y;
         res_carry_d   = head_illegal ? 1'b0 : bus.alu_carry;
`ifdef ALU_ZERO_FLAG_EN
         res_zero_d    = head_illegal | (bus.alu_y == '0);
`endif
      end else if (res_valid_q & bus.res_ready) begin
         res_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         level_q       <= '0;
         res_valid_q   <= 1'b0;
         res_y_q       <= '0;
         res_carry_q   <= 1'b0;
         res_op_q      <= '0;
         res_illegal_q <= 1'b0;
`ifdef ALU_ZERO_FLAG_EN
         res_zero_q    <= 1'b0;
`endif
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         level_q       <= level_d;
         res_valid_q   <= res_valid_d;
         res_y_q       <= res_y_d;
         res_carry_q   <= res_carry_d;
         res_op_q      <= res_op_d;
         res_illegal_q <= res_illegal_d;
`ifdef ALU_ZERO_FLAG_EN
         res_zero_q    <= res_zero_d;
`endif
      end
   end

   // NOTE: the storage array is deliberately not reset; level_q gates every read, so flushing the pointers is enough.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b};
      end
   end
endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: directed scenarios plus a randomized run
// against a queue-based reference model; a behavioural ALU stands in for top_alu.
module tb_alu_issue_queue;
   localparam int DEPTH = 4;
   localparam int WIDTH = 32;
   localparam int LVL_W = $clog2(DEPTH + 1);

   typedef logic [WIDTH-1:0] word_t;
   typedef struct {
      logic [3:0] op;
      word_t      a;
      word_t      b;
   } cmd_t;
   typedef struct {
      word_t      y;
      logic       carry;
      logic [3:0] op;
      logic       illegal;
      logic       zero;
   } res_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   alu_issue_queue_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

   alu_issue_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Stand-in for top_alu; illegal opcodes deliberately return non-zero junk.
   function automatic logic [WIDTH:0] alu_fn(input logic [3:0] op, input word_t a, input word_t b);
      case (op)
         4'd0:    return {1'b0, a} + {1'b0, b};
         4'd1:    return {1'b0, a} - {1'b0, b};
         4'd2:    return {1'b0, a & b};
         4'd3:    return {1'b0, a | b};
         4'd4:    return {1'b0, a ^ b};
         4'd5:    return {1'b0, ~a};
         4'd6:    return {a, 1'b0};
         4'd7:    return {a[0], 1'b0, a[WIDTH-1:1]};
         4'd8:    return {1'b0, a * b};
         4'd9:    return {1'b0, a};
         4'd10:   return {1'b0, b};
         default: return {1'b1, a ^ b ^ 32'hDEAD_BEEF};
      endcase
   endfunction

   function automatic res_t expect_res(input cmd_t c);
      res_t             r;
      logic [WIDTH:0]   raw;
      raw       = alu_fn(c.op, c.a, c.b);
      r.op      = c.op;
      r.illegal = (c.op > 4'd10);
      r.y       = r.illegal ? '0 : raw[WIDTH-1:0];
      r.carry   = r.illegal ? 1'b0 : raw[WIDTH];
      r.zero    = r.illegal | (raw[WIDTH-1:0] == '0);
      return r;
   endfunction

   always_comb {bus.alu_carry, bus.alu_y} = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic v, input logic [3:0] op, input word_t a, input word_t b, input logic rr);
      bus.cmd_valid = v;
      bus.cmd_op    = op;
      bus.cmd_a     = a;
      bus.cmd_b     = b;
      bus.res_ready = rr;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, 4'd0, '0, '0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %0b want 0", bus.res_valid); end
      checks++; if (bus.level !== '0) begin errors++; $display("FAIL reset_level got %0d want 0", bus.level); end
      checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %0b want 1", bus.cmd_ready); end
      checks++; if ({bus.res_y, bus.res_carry, bus.res_op, bus.res_illegal} !== '0) begin errors++; $display("FAIL reset_res_fields got y=%0h c=%0b op=%0d ill=%0b want 0", bus.res_y, bus.res_carry, bus.res_op, bus.res_illegal); end
      checks++; if ({bus.alu_a, bus.alu_b, bus.alu_op} !== '0) begin errors++; $display("FAIL reset_alu_drive got a=%0h b=%0h op=%0d want 0", bus.alu_a, bus.alu_b, bus.alu_op); end
`ifdef ALU_ZERO_FLAG_EN
      checks++; if (bus.res_zero !== 1'b0) begin errors++; $display("FAIL reset_res_zero got %0b want 0", bus.res_zero); end
`endif
      next_cycle();
      rst = 1'b0;
   endtask

   task automatic test_single();
      drive(1'b1, 4'd0, 32'd56, 32'd32, 1'b1);
      @(negedge clk);
      checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %0b want 1", bus.cmd_ready); end
      checks++; if ({bus.alu_a, bus.alu_op} !== '0) begin errors++; $display("FAIL single_no_bypass got a=%0d op=%0d want 0", bus.alu_a, bus.alu_op); end
      next_cycle();
      drive(1'b0, 4'd0, '0, '0, 1'b1);
      @(negedge clk);
      checks++; if (bus.level !== LVL_W'(1)) begin errors++; $display("FAIL single_level got %0d want 1", bus.level); end
      checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %0b want 0", bus.res_valid); end
      checks++; if (bus.alu_a !== 32'd56 || bus.alu_b !== 32'd32 || bus.alu_op !== 4'd0) begin errors++; $display("FAIL single_head got a=%0d b=%0d op=%0d want 56 32 0", bus.alu_a, bus.alu_b, bus.alu_op); end
      next_cycle();
      @(negedge clk);
      checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", bus.res_valid); end
      checks++; if (bus.res_y !== 32'd88 || bus.res_carry !== 1'b0) begin errors++; $display("FAIL single_result got y=%0d c=%0b want 88 0", bus.res_y, bus.res_carry); end
      checks++; if (bus.res_op !== 4'd0 || bus.res_illegal !== 1'b0) begin errors++; $display("FAIL single_op got op=%0d ill=%0b want 0 0", bus.res_op, bus.res_illegal); end
      next_cycle();
      @(negedge clk);
      checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %0b want 0", bus.res_valid); end
      next_cycle();
   endtask

   task automatic test_back_to_back();
      logic [3:0] ops [6];
      word_t      exp [6];
      ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd10};
      exp = '{32'd24, 32'd32, 32'd56, 32'd24, 32'd56, 32'd32};
      for (int c = 0; c < 8; c++) begin
         if (c < 6) drive(1'b1, ops[c], 32'd56, 32'd32, 1'b1);
         else       drive(1'b0, 4'd0, '0, '0, 1'b1);
         @(negedge clk);
         if (c >= 2) begin
            checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL b2b_bubble[%0d] got %0b want 1", c - 2, bus.res_valid); end
            checks++; if (bus.res_y !== exp[c-2] || bus.res_op !== ops[c-2]) begin errors++; $display("FAIL b2b_result[%0d] got y=%0d op=%0d want %0d %0d", c - 2, bus.res_y, bus.res_op, exp[c-2], ops[c-2]); end
         end
         next_cycle();
      end
      @(negedge clk);
      checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0b want 0", bus.res_valid); end
      next_cycle();
   endtask

   task automatic test_backpressure();
      logic exp_ready [6];
      exp_ready = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 4'd0, word_t'(100 + i), word_t'(i), 1'b0);
         @(negedge clk);
         checks++; if (bus.cmd_ready !== exp_ready[i]) begin errors++; $display("FAIL bp_accept[%0d] got %0b want %0b", i, bus.cmd_ready, exp_ready[i]); end
         next_cycle();
      end
      drive(1'b0, 4'd0, '0, '0, 1'b0);
      for (int h = 0; h < 3; h++) begin
         @(negedge clk);
         checks++; if (bus.level !== LVL_W'(DEPTH) || bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_full[%0d] got level=%0d ready=%0b want 4 0", h, bus.level, bus.cmd_ready); end
         checks++; if (bus.res_valid !== 1'b1 || bus.res_y !== 32'd100 || bus.res_op !== 4'd0) begin errors++; $display("FAIL bp_hold[%0d] got v=%0b y=%0d op=%0d want 1 100 0", h, bus.res_valid, bus.res_y, bus.res_op); end
         next_cycle();
      end
      drive(1'b0, 4'd0, '0, '0, 1'b1);
      for (int d = 0; d < 5; d++) begin
         @(negedge clk);
         checks++; if (bus.res_valid !== 1'b1 || bus.res_y !== word_t'(100 + 2 * d)) begin errors++; $display("FAIL bp_drain[%0d] got v=%0b y=%0d want 1 %0d", d, bus.res_valid, bus.res_y, 100 + 2 * d); end
         next_cycle();
      end
      @(negedge clk);
      checks++; if (bus.res_valid !== 1'b0 || bus.level !== '0) begin errors++; $display("FAIL bp_empty got v=%0b level=%0d want 0 0", bus.res_valid, bus.level); end
      next_cycle();
   endtask

   task automatic test_illegal();
      drive(1'b1, 4'd12, 32'd7, 32'd7, 1'b1);
      @(negedge clk); next_cycle();
      drive(1'b1, 4'd0, 32'd56, 32'd32, 1'b1);
      @(negedge clk); next_cycle();
      drive(1'b0, 4'd0, '0, '0, 1'b1);
      @(negedge clk);
      checks++; if (bus.res_valid !== 1'b1 || bus.res_illegal !== 1'b1 || bus.res_op !== 4'd12) begin errors++; $display("FAIL illegal_flag got v=%0b ill=%0b op=%0d want 1 1 12", bus.res_valid, bus.res_illegal, bus.res_op); end
      checks++; if (bus.res_y !== '0 || bus.res_carry !== 1'b0) begin errors++; $display("FAIL illegal_forced got y=%0h c=%0b want 0 0", bus.res_y, bus.res_carry); end
`ifdef ALU_ZERO_FLAG_EN
      checks++; if (bus.res_zero !== 1'b1) begin errors++; $display("FAIL illegal_zero got %0b want 1", bus.res_zero); end
`endif
      next_cycle();
      @(negedge clk);
      checks++; if (bus.res_valid !== 1'b1 || bus.res_y !== 32'd88 || bus.res_illegal !== 1'b0) begin errors++; $display("FAIL illegal_next got v=%0b y=%0d ill=%0b want 1 88 0", bus.res_valid, bus.res_y, bus.res_illegal); end
      next_cycle();
      @(negedge clk);
      next_cycle();
   endtask

`ifdef ALU_ZERO_FLAG_EN
   task automatic test_zero_flag();
      drive(1'b1, 4'd4, 32'd56, 32'd56, 1'b1);
      next_cycle();
      drive(1'b1, 4'd0, 32'd56, 32'd32, 1'b1);
      next_cycle();
      drive(1'b0, 4'd0, '0, '0, 1'b1);
      @(negedge clk);
      checks++; if (bus.res_valid !== 1'b1 || bus.res_zero !== 1'b1) begin errors++; $display("FAIL zero_xor got v=%0b z=%0b want 1 1", bus.res_valid, bus.res_zero); end
      next_cycle();
      @(negedge clk);
      checks++; if (bus.res_valid !== 1'b1 || bus.res_zero !== 1'b0) begin errors++; $display("FAIL zero_add got v=%0b z=%0b want 1 0", bus.res_valid, bus.res_zero); end
      next_cycle();
      next_cycle();
   endtask
`endif

   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 4'd0, word_t'(10 * i + 1), 32'd1, 1'b0);
         next_cycle();
      end
      drive(1'b0, 4'd0, '0, '0, 1'b0);
      @(negedge clk);
      checks++; if (bus.level !== LVL_W'(3) || bus.res_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre got level=%0d v=%0b want 3 1", bus.level, bus.res_valid); end
      rst = 1'b1;
      #1;
      checks++; if (bus.res_valid !== 1'b0 || bus.level !== '0 || bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_async got v=%0b level=%0d ready=%0b want 0 0 1", bus.res_valid, bus.level, bus.cmd_ready); end
      checks++; if ({bus.alu_a, bus.alu_op, bus.res_y} !== '0) begin errors++; $display("FAIL rstmid_clear got a=%0h op=%0d y=%0h want 0", bus.alu_a, bus.alu_op, bus.res_y); end
      next_cycle();
      rst = 1'b0;
      drive(1'b0, 4'd0, '0, '0, 1'b1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++; if (bus.res_valid !== 1'b0 || bus.level !== '0) begin errors++; $display("FAIL rstmid_stale[%0d] got v=%0b level=%0d want 0 0", c, bus.res_valid, bus.level); end
         next_cycle();
      end
   endtask

   task automatic test_random();
      cmd_t  q [$];
      logic  rv;
      res_t  r;
      cmd_t  c;
      logic  v, rr, do_issue;
      int    results;
      rv      = 1'b0;
      r       = '{default: '0};
      results = 0;
      for (int n = 0; n < 600; n++) begin
         v    = ($urandom_range(0, 99) < 70);
         rr   = ($urandom_range(0, 99) < 60);
         c.op = 4'($urandom_range(0, 15));
         c.a  = ($urandom_range(0, 3) == 0) ? word_t'($urandom_range(0, 8)) : word_t'($urandom);
         c.b  = ($urandom_range(0, 3) == 0) ? c.a : word_t'($urandom);
         drive(v, c.op, c.a, c.b, rr);
         @(negedge clk);
         checks++; if (bus.cmd_ready !== (q.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready[%0d] got %0b want %0b", n, bus.cmd_ready, q.size() < DEPTH); end
         checks++; if (bus.level !== LVL_W'(q.size())) begin errors++; $display("FAIL rnd_level[%0d] got %0d want %0d", n, bus.level, q.size()); end
         checks++; if (bus.res_valid !== rv) begin errors++; $display("FAIL rnd_valid[%0d] got %0b want %0b", n, bus.res_valid, rv); end
         if (q.size() > 0) begin
            checks++; if (bus.alu_op !== q[0].op || bus.alu_a !== q[0].a || bus.alu_b !== q[0].b) begin errors++; $display("FAIL rnd_head[%0d] got op=%0d a=%0h b=%0h want %0d %0h %0h", n, bus.alu_op, bus.alu_a, bus.alu_b, q[0].op, q[0].a, q[0].b); end
         end else begin
            checks++; if ({bus.alu_a, bus.alu_b, bus.alu_op} !== '0) begin errors++; $display("FAIL rnd_idle_drive[%0d] got a=%0h b=%0h op=%0d want 0", n, bus.alu_a, bus.alu_b, bus.alu_op); end
         end
         if (rv) begin
            checks++; if (bus.res_y !== r.y || bus.res_carry !== r.carry || bus.res_op !== r.op || bus.res_illegal !== r.illegal) begin errors++; $display("FAIL rnd_result[%0d] got y=%0h c=%0b op=%0d ill=%0b want %0h %0b %0d %0b", n, bus.res_y, bus.res_carry, bus.res_op, bus.res_illegal, r.y, r.carry, r.op, r.illegal); end
`ifdef ALU_ZERO_FLAG_EN
            checks++; if (bus.res_zero !== r.zero) begin errors++; $display("FAIL rnd_zero[%0d] got %0b want %0b", n, bus.res_zero, r.zero); end
`endif
         end
         do_issue = (q.size() > 0) && (!rv || rr);
         if (rv && rr) results++;
         if (do_issue) begin
            r  = expect_res(q.pop_front());
            rv = 1'b1;
         end else if (rv && rr) begin
            rv = 1'b0;
         end
         if (v && (q.size() + (do_issue ? 1 : 0)) < DEPTH) q.push_back(c);
         next_cycle();
      end
      checks++; if (results < 50) begin errors++; $display("FAIL rnd_activity got %0d results want at least 50", results); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_illegal();
`ifdef ALU_ZERO_FLAG_EN
      test_zero_flag();
`endif
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

Command buffer and result-capture stage wrapped around `top_alu`. Accepts ALU commands (op, A, B) over a valid/ready handshake and queues them in a small FIFO. Drives the head entry onto the combinational `top_alu` inputs, registers `Y`/`carry` into an output register, and presents results downstream with a valid/ready handshake. Lets the combinational ALU sit in a back-pressured, one-result-per-cycle pipeline.

## Interface

- `DEPTH`, 4: command FIFO entries; power of two, ≥ 2
- `WIDTH`, 32: operand/result width; must match `top_alu`
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  queue can accept
- `cmd_op`  in  4  ALU opcode (0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 LSHIFT, 7 RSHIFT, 8 MUL, 9 MOV A, 10 MOV B)
- `cmd_a`, `cmd_b`  in  WIDTH  operands
- `alu_a`, `alu_b`  out  WIDTH  to `top_alu` A/B
- `alu_op`  out  4  to `top_alu` op
- `alu_y`  in  WIDTH  from `top_alu` Y
- `alu_carry`  in  1  from `top_alu` carry
- `res_valid`  out  1  result register occupied
- `res_ready`  in  1  downstream accepts
- `res_y`  out  WIDTH  captured result
- `res_carry`  out  1  captured carry
- `res_op`  out  4  opcode that produced the result
- `res_illegal`  out  1  opcode was 11–15
- `level`  out  $clog2(DEPTH+1)  FIFO occupancy, excluding the result register
- `res_zero`  out  1  present only with `ALU_ZERO_FLAG_EN`

## Operation

- Push: `cmd_valid & cmd_ready` writes {op, a, b} at the tail.
- `cmd_ready` = FIFO not full. It is registered-state based only and has no combinational path from `res_ready`.
- Head drive:
  - FIFO non-empty: `alu_a/alu_b/alu_op` = head entry, combinationally.
  - FIFO empty: all three are 0.
- Issue condition: FIFO non-empty AND (`!res_valid` OR `res_ready`).
- On issue, the result register loads on the next edge:
  - `res_y` ← `alu_y`, `res_carry` ← `alu_carry`, `res_op` ← head op.
  - `res_illegal` ← (op > 10).
  - The head is popped and `res_valid` ← 1.
- Illegal op (11–15): `res_y` = 0 and `res_carry` = 0, forced regardless of ALU output; `res_illegal` = 1. The entry still flows through and occupies one result slot.
- Drain with no issue: `res_valid & res_ready` and FIFO empty → `res_valid` ← 0 next edge.
- Hold: while `res_valid & !res_ready`, all `res_*` stay stable and the head is not popped.
- Simultaneous push and pop in one cycle: both take effect and `level` is unchanged. A push is impossible when full.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. Full/empty are derived from `level`.
- Operands are never modified by this block. The ALU's width/carry semantics pass through unchanged.

## Timing

- Reset (async assert, sync-safe deassert):
  - FIFO flushed, `level` = 0, `cmd_ready` = 1.
  - `res_valid` = 0; `res_y`, `res_carry`, `res_op`, `res_illegal`, `res_zero` = 0.
  - `alu_a/alu_b/alu_op` = 0.
- Reset mid-operation discards all queued and captured commands. No result emerges for them.
- Latency: command accepted at edge k → `res_valid` = 1 after edge k+1. There is no same-cycle bypass from `cmd_*` to `alu_*`.
- Throughput: one result per cycle with `res_ready` held high.
- Capacity under back-pressure: DEPTH + 1 commands. DEPTH sit in the FIFO and one sits in the result register.
- `top_alu` must settle (including MUL) within one `clk` period.

## Configuration

- `ALU_ZERO_FLAG_EN` defined:
  - `res_zero` port exists.
  - `res_zero` ← (`alu_y` == 0) on issue, and holds with the other `res_*` outputs.
  - `res_zero` = 1 for illegal ops.
- `ALU_ZERO_FLAG_EN` undefined: no `res_zero` port and no compare logic. All other behaviour is identical.

## Test plan

- Single command, A=56, B=32, op=0, `res_ready`=1 → one cycle after accept: `res_y`=88, `res_carry`=0, `res_op`=0, `res_illegal`=0.
- Back-to-back ops 1, 2, 3, 4, 9, 10 on A=56, B=32 → consecutive cycles yield 24, 32, 56, 24, 56, 32, in order, with no bubbles.
- `res_ready`=0 and 6 commands offered → exactly 5 accepted. `cmd_ready`=0 with `level`=4, and `res_*` stable. Releasing `res_ready` drains all 5 in order on 5 consecutive cycles.
- op=12, A=B=7 → `res_illegal`=1, `res_y`=0, `res_carry`=0. The following op=0 command still completes normally.
- Assert `rst` with 3 commands queued and `res_valid`=1 → immediately `res_valid`=0, `level`=0, `cmd_ready`=1. After release, no stale result appears.
- With `ALU_ZERO_FLAG_EN`: op=4, A=B=56 → `res_zero`=1; op=0, A=56, B=32 → `res_zero`=0.
